uart_tx_arbiter: RTL and testbench

Round-robin scheduler that lets NUM_REQ independent requesters share the transmit side of one UART instance. It accepts 32-bit words over a valid/ready handshake and issues each word to the UART as a TxData/TxReq transfer. It tracks TxBusy to completion and reports a done/error status tagged with the requester id. It sits between client logic and the UART's TxData/TxReq/TxBusy pins, one instance per UART.

---
 rtl/uart_ctrl_pkg.sv | 13 +
 rtl/uart_tx_arbiter_rr_arbiter.sv | 43 ++++
 rtl/uart_tx_arbiter.sv | 110 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared word width and transmit FSM state type for the UART controller
package uart_ctrl_pkg;

  localparam int DATA_BITS = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rtl/uart_tx_arbiter_rr_arbiter.sv - round-robin winner pick with a registered rotating pointer
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   i_req,
  input  logic           i_advance,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_id
);

  logic [IDW-1:0] r_ptr;
  logic [IDW:0]   w_idx;
  logic           w_found;

  // Scan upward from the pointer with wrap; the first set request wins.
  always_comb begin
    o_grant = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_idx >= (IDW+1)'(N)) w_idx = w_idx - (IDW+1)'(N);
      if (!w_found && i_req[w_idx[IDW-1:0]]) begin
        w_found                   = 1'b1;
        o_grant[w_idx[IDW-1:0]]   = 1'b1;
        o_id                      = w_idx[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_id == IDW'(N-1)) ? '0 : o_id + IDW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter among NUM_REQ requesters, reports done/timeout per word
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = uart_ctrl_pkg::DATA_BITS,
  parameter int BUSY_TIMEOUT = 64,
  parameter int IDW          = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_BITS-1:0]         uart_tx_data,
  output logic                         uart_tx_req,
  input  logic                         uart_tx_busy,
  output logic                         done_valid,
  output logic [IDW-1:0]               done_id,
  output logic                         done_err,
  output logic                         busy
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [DATA_BITS-1:0] r_data;
  logic [IDW-1:0]       r_id;
  logic [IDW-1:0]       r_last_id;
  logic [IDW-1:0]       w_win_id;
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_grant_go;
  logic                 w_done;
  logic                 w_err;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst_n     (reset),
    .i_req     (req_valid),
    .i_advance (w_grant_go),
    .o_grant   (w_grant),
    .o_id      (w_win_id)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant_go  = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req_valid && !uart_tx_busy) begin
          w_grant_go  = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: w_state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (uart_tx_busy) begin
          w_state_nxt = WAIT_DONE;
        end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
          w_done      = 1'b1;
          w_err       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_data    <= '0;
      r_id      <= '0;
      r_last_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_go) begin
        r_data <= req_data[int'(w_win_id) * DATA_BITS +: DATA_BITS];
        r_id   <= w_win_id;
      end
      if (r_state == ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == WAIT_BUSY && !uart_tx_busy) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_done) r_last_id <= r_id;
    end
  end

  // req_ready is combinational from the grant, so it is gated while reset is held.
  assign req_ready    = (w_grant_go && reset) ? w_grant : '0;
  assign uart_tx_data = r_data;
  assign uart_tx_req  = (r_state == ISSUE);
  assign done_valid   = w_done;
  assign done_err     = w_err;
  assign done_id      = w_done ? r_id : r_last_id;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a simple UART busy model
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DB = 32;
  localparam int BT = 64;
  localparam int IW = 2;

  logic             clk;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*DB-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [DB-1:0]    uart_tx_data;
  logic             uart_tx_req;
  logic             uart_tx_busy;
  logic             done_valid;
  logic [IW-1:0]    done_id;
  logic             done_err;
  logic             busy;

  logic model_busy;
  logic hold_busy;
  logic model_never;
  int   busy_delay;
  int   busy_len;

  int n_checks;
  int n_fail;
  int cyc;
  int onehot_bad;

  int            exp_id_q[$];
  logic [DB-1:0] exp_dat_q[$];
  logic          exp_err_q[$];
  int            g_id_q[$];
  int            g_cyc_q[$];
  logic [DB-1:0] tx_q[$];
  int            tx_cyc_q[$];
  int            d_id_q[$];
  logic          d_err_q[$];
  int            d_cyc_q[$];

  assign uart_tx_busy = model_busy | hold_busy;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .BUSY_TIMEOUT(BT), .IDW(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .uart_tx_data (uart_tx_data),
    .uart_tx_req  (uart_tx_req),
    .uart_tx_busy (uart_tx_busy),
    .done_valid   (done_valid),
    .done_id      (done_id),
    .done_err     (done_err),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // UART model: busy rises busy_delay cycles after the TxReq cycle and stays up busy_len cycles.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (uart_tx_req && !model_never) begin
        repeat (busy_delay) begin @(posedge clk); #2; end
        model_busy = 1'b1;
        repeat (busy_len) begin @(posedge clk); #2; end
        model_busy = 1'b0;
      end
    end
  end

  initial begin
    cyc = 0;
    onehot_bad = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        if (req_ready != '0 && !$onehot(req_ready)) onehot_bad++;
        for (int i = 0; i < NR; i++)
          if (req_ready[i]) begin g_id_q.push_back(i); g_cyc_q.push_back(cyc); end
        if (uart_tx_req) begin tx_q.push_back(uart_tx_data); tx_cyc_q.push_back(cyc); end
        if (done_valid) begin
          d_id_q.push_back(int'(done_id));
          d_err_q.push_back(done_err);
          d_cyc_q.push_back(cyc);
        end
      end
    end
  end

  task automatic clear_obs();
    exp_id_q.delete(); exp_dat_q.delete(); exp_err_q.delete();
    g_id_q.delete(); g_cyc_q.delete(); tx_q.delete(); tx_cyc_q.delete();
    d_id_q.delete(); d_err_q.delete(); d_cyc_q.delete();
  endtask

  task automatic wait_obs(input int ng, input int nd, input int budget, output bit to);
    int n;
    n = 0;
    while ((g_id_q.size() < ng || d_id_q.size() < nd) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    to = (g_id_q.size() < ng || d_id_q.size() < nd);
  endtask

  task automatic push_exp(input int id, input logic [DB-1:0] dat, input logic err);
    exp_id_q.push_back(id);
    exp_dat_q.push_back(dat);
    exp_err_q.push_back(err);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < NR; i++) req_data[i*DB +: DB] = 32'hCAFE_0000 + i;
    @(negedge clk);
    n_checks += 7;
    if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_req_ready: got %h expected 0", req_ready); end
    if (uart_tx_data !== 32'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 0", uart_tx_data); end
    if (uart_tx_req !== 1'b0) begin n_fail++; $display("FAIL reset_tx_req: got %b expected 0", uart_tx_req); end
    if (done_valid !== 1'b0) begin n_fail++; $display("FAIL reset_done_valid: got %b expected 0", done_valid); end
    if (done_id !== 2'd0) begin n_fail++; $display("FAIL reset_done_id: got %0d expected 0", done_id); end
    if (done_err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err: got %b expected 0", done_err); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    req_valid = '0;
    reset = 1'b1;
  endtask

  task automatic test_single();
    bit to;
    int eid, gid, did, lat;
    logic [DB-1:0] edat, tdat;
    logic eerr, derr;
    clear_obs();
    req_data[0 +: DB] = 32'hDEAD_BEEF;
    req_valid = 4'b0001;
    push_exp(0, 32'hDEAD_BEEF, 1'b0);
    wait_obs(1, 0, 50, to);
    req_valid = '0;
    wait_obs(1, 1, 100, to);
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (to) begin n_fail++; $display("FAIL single_timeout: got no completion expected one within budget"); end
    n_checks++;
    if (g_id_q.size() != 1) begin n_fail++; $display("FAIL single_ready_pulses: got %0d expected 1", g_id_q.size()); end
    lat = (tx_cyc_q.size() > 0 && d_cyc_q.size() > 0) ? d_cyc_q[0] - tx_cyc_q[0] : -1;
    n_checks++;
    if (lat != 12) begin n_fail++; $display("FAIL single_done_latency: got %0d expected 12", lat); end
    while (exp_id_q.size() > 0) begin
      eid = exp_id_q.pop_front(); edat = exp_dat_q.pop_front(); eerr = exp_err_q.pop_front();
      gid = (g_id_q.size() > 0) ? g_id_q.pop_front() : -1;
      tdat = (tx_q.size() > 0) ? tx_q.pop_front() : 'x;
      did = (d_id_q.size() > 0) ? d_id_q.pop_front() : -1;
      derr = (d_err_q.size() > 0) ? d_err_q.pop_front() : 1'bx;
      n_checks += 4;
      if (gid !== eid) begin n_fail++; $display("FAIL single_grant_id: got %0d expected %0d", gid, eid); end
      if (tdat !== edat) begin n_fail++; $display("FAIL single_tx_data: got %h expected %h", tdat, edat); end
      if (did !== eid) begin n_fail++; $display("FAIL single_done_id: got %0d expected %0d", did, eid); end
      if (derr !== eerr) begin n_fail++; $display("FAIL single_done_err: got %b expected %b", derr, eerr); end
    end
  endtask

  task automatic test_round_robin();
    bit to;
    int eid, gid, did;
    logic [DB-1:0] edat, tdat;
    logic eerr, derr;
    do_reset();
    clear_obs();
    onehot_bad = 0;
    for (int i = 0; i < NR; i++) req_data[i*DB +: DB] = 32'h100 + i;
    for (int k = 0; k < 5; k++) push_exp(k % NR, 32'h100 + (k % NR), 1'b0);
    req_valid = 4'hF;
    wait_obs(5, 5, 300, to);
    req_valid = '0;
    repeat (3) @(posedge clk); #1;
    n_checks += 3;
    if (to) begin n_fail++; $display("FAIL rr_timeout: got %0d completions expected 5", d_id_q.size()); end
    if (onehot_bad != 0) begin n_fail++; $display("FAIL rr_onehot: got %0d bad cycles expected 0", onehot_bad); end
    if (g_id_q.size() != 5) begin n_fail++; $display("FAIL rr_grant_count: got %0d expected 5", g_id_q.size()); end
    while (exp_id_q.size() > 0) begin
      eid = exp_id_q.pop_front(); edat = exp_dat_q.pop_front(); eerr = exp_err_q.pop_front();
      gid = (g_id_q.size() > 0) ? g_id_q.pop_front() : -1;
      tdat = (tx_q.size() > 0) ? tx_q.pop_front() : 'x;
      did = (d_id_q.size() > 0) ? d_id_q.pop_front() : -1;
      derr = (d_err_q.size() > 0) ? d_err_q.pop_front() : 1'bx;
      n_checks += 4;
      if (gid !== eid) begin n_fail++; $display("FAIL rr_grant_id: got %0d expected %0d", gid, eid); end
      if (tdat !== edat) begin n_fail++; $display("FAIL rr_tx_data: got %h expected %h", tdat, edat); end
      if (did !== eid) begin n_fail++; $display("FAIL rr_done_id: got %0d expected %0d", did, eid); end
      if (derr !== eerr) begin n_fail++; $display("FAIL rr_done_err: got %b expected %b", derr, eerr); end
    end
  endtask

  task automatic test_wrap();
    bit to;
    int eid, gid, did;
    logic [DB-1:0] edat, tdat;
    logic eerr, derr;
    clear_obs();
    req_data[3*DB +: DB] = 32'h3333_0003;
    req_data[0*DB +: DB] = 32'h0000_AAAA;
    req_data[2*DB +: DB] = 32'h2222_BBBB;
    push_exp(3, 32'h3333_0003, 1'b0);
    push_exp(0, 32'h0000_AAAA, 1'b0);
    req_valid = 4'b1000;
    wait_obs(1, 0, 50, to);
    req_valid = 4'b0101;
    wait_obs(2, 0, 100, to);
    req_valid = '0;
    wait_obs(2, 2, 100, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL wrap_timeout: got %0d completions expected 2", d_id_q.size()); end
    while (exp_id_q.size() > 0) begin
      eid = exp_id_q.pop_front(); edat = exp_dat_q.pop_front(); eerr = exp_err_q.pop_front();
      gid = (g_id_q.size() > 0) ? g_id_q.pop_front() : -1;
      tdat = (tx_q.size() > 0) ? tx_q.pop_front() : 'x;
      did = (d_id_q.size() > 0) ? d_id_q.pop_front() : -1;
      derr = (d_err_q.size() > 0) ? d_err_q.pop_front() : 1'bx;
      n_checks += 4;
      if (gid !== eid) begin n_fail++; $display("FAIL wrap_grant_id: got %0d expected %0d", gid, eid); end
      if (tdat !== edat) begin n_fail++; $display("FAIL wrap_tx_data: got %h expected %h", tdat, edat); end
      if (did !== eid) begin n_fail++; $display("FAIL wrap_done_id: got %0d expected %0d", did, eid); end
      if (derr !== eerr) begin n_fail++; $display("FAIL wrap_done_err: got %b expected %b", derr, eerr); end
    end
  endtask

  task automatic test_timeout();
    bit to;
    int eid, gid, did, lat;
    logic [DB-1:0] edat, tdat;
    logic eerr, derr;
    clear_obs();
    model_never = 1'b1;
    req_data[1*DB +: DB] = 32'hA5A5_0001;
    req_valid = 4'b0010;
    push_exp(1, 32'hA5A5_0001, 1'b1);
    wait_obs(1, 0, 50, to);
    req_valid = '0;
    wait_obs(1, 1, 200, to);
    n_checks += 2;
    if (to) begin n_fail++; $display("FAIL timeout_no_done: got none expected error completion"); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_back_to_idle: got busy=%b expected 0", busy); end
    lat = (tx_cyc_q.size() > 0 && d_cyc_q.size() > 0) ? d_cyc_q[0] - tx_cyc_q[0] : -1;
    n_checks++;
    if (lat != BT) begin n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", lat, BT); end
    model_never = 1'b0;
    req_data[2*DB +: DB] = 32'h0BAD_F00D;
    req_valid = 4'b0100;
    push_exp(2, 32'h0BAD_F00D, 1'b0);
    wait_obs(2, 1, 50, to);
    req_valid = '0;
    wait_obs(2, 2, 100, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL timeout_recovery: got %0d completions expected 2", d_id_q.size()); end
    while (exp_id_q.size() > 0) begin
      eid = exp_id_q.pop_front(); edat = exp_dat_q.pop_front(); eerr = exp_err_q.pop_front();
      gid = (g_id_q.size() > 0) ? g_id_q.pop_front() : -1;
      tdat = (tx_q.size() > 0) ? tx_q.pop_front() : 'x;
      did = (d_id_q.size() > 0) ? d_id_q.pop_front() : -1;
      derr = (d_err_q.size() > 0) ? d_err_q.pop_front() : 1'bx;
      n_checks += 4;
      if (gid !== eid) begin n_fail++; $display("FAIL timeout_grant_id: got %0d expected %0d", gid, eid); end
      if (tdat !== edat) begin n_fail++; $display("FAIL timeout_tx_data: got %h expected %h", tdat, edat); end
      if (did !== eid) begin n_fail++; $display("FAIL timeout_done_id: got %0d expected %0d", did, eid); end
      if (derr !== eerr) begin n_fail++; $display("FAIL timeout_done_err: got %b expected %b", derr, eerr); end
    end
  endtask

  task automatic test_busy_idle();
    bit to;
    int drop_cyc, gcyc, gid;
    clear_obs();
    hold_busy = 1'b1;
    req_data[0 +: DB] = 32'h1234_5678;
    req_valid = 4'b0001;
    repeat (10) @(posedge clk);
    #1;
    n_checks += 2;
    if (g_id_q.size() != 0) begin n_fail++; $display("FAIL busy_idle_no_grant: got %0d grants expected 0", g_id_q.size()); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle_state: got busy=%b expected 0", busy); end
    hold_busy = 1'b0;
    drop_cyc = cyc;
    wait_obs(1, 0, 20, to);
    req_valid = '0;
    gcyc = (g_cyc_q.size() > 0) ? g_cyc_q[0] : -1;
    gid = (g_id_q.size() > 0) ? g_id_q[0] : -1;
    n_checks += 2;
    if (gcyc != drop_cyc + 1) begin n_fail++; $display("FAIL busy_idle_grant_cycle: got %0d expected %0d", gcyc, drop_cyc + 1); end
    if (gid != 0) begin n_fail++; $display("FAIL busy_idle_grant_id: got %0d expected 0", gid); end
    wait_obs(1, 1, 100, to);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit to;
    int eid, gid, did;
    logic [DB-1:0] edat, tdat;
    logic eerr, derr;
    clear_obs();
    req_data[2*DB +: DB] = 32'h7777_0002;
    req_valid = 4'b0100;
    wait_obs(1, 0, 50, to);
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || uart_tx_busy !== 1'b1) begin n_fail++; $display("FAIL midreset_setup: got busy=%b uart_busy=%b expected 1 1", busy, uart_tx_busy); end
    reset = 1'b0;
    #1;
    n_checks += 5;
    if (uart_tx_req !== 1'b0) begin n_fail++; $display("FAIL midreset_tx_req: got %b expected 0", uart_tx_req); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    if (done_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_done_valid: got %b expected 0", done_valid); end
    if (uart_tx_data !== 32'h0) begin n_fail++; $display("FAIL midreset_tx_data: got %h expected 0", uart_tx_data); end
    if (done_id !== 2'd0) begin n_fail++; $display("FAIL midreset_done_id: got %0d expected 0", done_id); end
    clear_obs();
    req_data[1*DB +: DB] = 32'h1111_0001;
    req_valid = 4'b0110;
    push_exp(1, 32'h1111_0001, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    wait_obs(1, 0, 50, to);
    req_valid = '0;
    wait_obs(1, 1, 100, to);
    repeat (3) @(posedge clk); #1;
    n_checks += 2;
    if (to) begin n_fail++; $display("FAIL midreset_recovery: got %0d completions expected 1", d_id_q.size()); end
    if (d_id_q.size() != 1) begin n_fail++; $display("FAIL midreset_done_count: got %0d expected 1", d_id_q.size()); end
    while (exp_id_q.size() > 0) begin
      eid = exp_id_q.pop_front(); edat = exp_dat_q.pop_front(); eerr = exp_err_q.pop_front();
      gid = (g_id_q.size() > 0) ? g_id_q.pop_front() : -1;
      tdat = (tx_q.size() > 0) ? tx_q.pop_front() : 'x;
      did = (d_id_q.size() > 0) ? d_id_q.pop_front() : -1;
      derr = (d_err_q.size() > 0) ? d_err_q.pop_front() : 1'bx;
      n_checks += 4;
      if (gid !== eid) begin n_fail++; $display("FAIL midreset_grant_id: got %0d expected %0d", gid, eid); end
      if (tdat !== edat) begin n_fail++; $display("FAIL midreset_tx_data: got %h expected %h", tdat, edat); end
      if (did !== eid) begin n_fail++; $display("FAIL midreset_done_id_after: got %0d expected %0d", did, eid); end
      if (derr !== eerr) begin n_fail++; $display("FAIL midreset_done_err: got %b expected %b", derr, eerr); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0;
    req_valid = '0;
    req_data = '0;
    hold_busy = 1'b0;
    model_never = 1'b0;
    busy_delay = 2;
    busy_len = 10;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_busy_idle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
